// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, grant
// tracking, the host payload captured at grant, and host lane timing.
package ram_arb_pkg;

  localparam int unsigned LANES        = 4;
  localparam int unsigned HOST_ACK_LAT = 5;
  localparam int unsigned LANE_CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOST     = 3'd1,
    ST_HOST_ACK = 3'd2,
    ST_CPU      = 3'd3,
    ST_CPU_ACK  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_CPU  = 1'b1
  } grant_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } host_req_t;

  // Byte lane k of a 32-bit word.
  function automatic logic [7:0] lane_byte(input logic [31:0] dat, input logic [1:0] lane);
    lane_byte = dat[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbitrates a 32-bit Wishbone host and an 8-bit CPU port onto one byte-wide RAM.
// Define RAM_ARB_HOST_PRIO_EN to give the host strict priority on ties.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              i_reset,
  input  logic [31:0]       i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  input  logic              i_wb_we,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  output logic [31:0]       o_wb_dat,
  output logic              o_wb_ack,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);
  localparam logic [LANE_CNT_W-1:0] DATA_DONE = LANE_CNT_W'(HOST_ACK_LAT - 1);

  arb_state_e            state_q, state_d;
  logic [LANE_CNT_W-1:0] lane_q, lane_d;
  grant_e                grant_q, grant_d;
  host_req_t             hreq_q, hreq_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  cpu_rd_q, cpu_rd_d;

  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_d, ram_we_q;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;
  logic                  wb_ack_q, wb_ack_d;
  logic [31:0]           wb_dat_q, wb_dat_d;
  logic                  cpu_ack_q, cpu_ack_d;

  logic                  host_req;
  logic                  pick_cpu;
  logic                  iss;
  logic [1:0]            iss_lane;
  logic [1:0]            cap_lane;
  logic                  unused_adr_bits;

  assign host_req        = i_wb_cyc & i_wb_stb;
  assign cap_lane        = 2'(lane_q - LANE_CNT_W'(1));
  assign unused_adr_bits = ^{i_wb_adr[31:ADDR_W], i_wb_adr[1:0]};

  // Tie-break: strict host priority, or alternate away from the last grantee.
`ifdef RAM_ARB_HOST_PRIO_EN
  assign pick_cpu = i_cpu_req & ~host_req;
`else
  assign pick_cpu = i_cpu_req & (~host_req | (grant_q == GRANT_HOST));
`endif

  // Next-state, lane sequencing and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    grant_d     = grant_q;
    hreq_d      = hreq_q;
    word_d      = word_q;
    cpu_rd_d    = cpu_rd_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = 8'h00;
    wb_ack_d    = 1'b0;
    wb_dat_d    = wb_dat_q;
    cpu_ack_d   = 1'b0;
    iss         = 1'b0;
    iss_lane    = 2'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (host_req || i_cpu_req) begin
          if (pick_cpu) begin
            state_d     = ST_CPU;
            grant_d     = GRANT_CPU;
            cpu_rd_d    = ~i_cpu_we;
            ram_en_d    = 1'b1;
            ram_we_d    = i_cpu_we;
            ram_addr_d  = i_cpu_addr;
            ram_wdata_d = i_cpu_we ? i_cpu_wdata : 8'h00;
          end else begin
            state_d    = ST_HOST;
            grant_d    = GRANT_HOST;
            lane_d     = '0;
            hreq_d.we  = i_wb_we;
            hreq_d.sel = i_wb_sel;
            hreq_d.dat = i_wb_dat;
            word_d     = i_wb_adr[ADDR_W-1:2];
            iss        = 1'b1;
            iss_lane   = 2'd0;
          end
        end
      end
      ST_HOST: begin
        lane_d = lane_q + LANE_CNT_W'(1);
        // Read data for the lane issued last cycle arrives now.
        if ((lane_q != '0) && !hreq_q.we) begin
          wb_dat_d[{cap_lane, 3'b000} +: 8] = i_ram_rdata;
        end
        if (lane_q < LAST_LANE) begin
          iss      = 1'b1;
          iss_lane = 2'(lane_q + LANE_CNT_W'(1));
        end
        if (lane_q == DATA_DONE) begin
          state_d  = ST_HOST_ACK;
          wb_ack_d = 1'b1;
        end
      end
      ST_HOST_ACK: state_d = ST_IDLE;
      ST_CPU: begin
        state_d   = ST_CPU_ACK;
        cpu_ack_d = 1'b1;
      end
      ST_CPU_ACK: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Host lane issue; unselected write lanes stay idle but keep their slot.
    if (iss) begin
      ram_en_d    = ~hreq_d.we | hreq_d.sel[iss_lane];
      ram_we_d    = hreq_d.we & hreq_d.sel[iss_lane];
      ram_addr_d  = {word_d, iss_lane};
      ram_wdata_d = ram_we_d ? lane_byte(hreq_d.dat, iss_lane) : 8'h00;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      grant_q     <= GRANT_HOST;
      hreq_q      <= '0;
      word_q      <= '0;
      cpu_rd_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h00;
      wb_ack_q    <= 1'b0;
      wb_dat_q    <= 32'h0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      grant_q     <= grant_d;
      hreq_q      <= hreq_d;
      word_q      <= word_d;
      cpu_rd_q    <= cpu_rd_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wb_ack_q    <= wb_ack_d;
      wb_dat_q    <= wb_dat_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign o_ram_en    = ram_en_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_wb_ack    = wb_ack_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_cpu_ack   = cpu_ack_q;
  // RAM read data lands in the ack cycle itself, so the CPU byte is passed through.
  assign o_cpu_rdata = (cpu_ack_q && cpu_rd_q) ? i_ram_rdata : 8'h00;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-schedule reference model checked every
// cycle, plus directed literal checks; covers RAM_ARB_HOST_PRIO_EN when defined.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef RAM_ARB_HOST_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          wb_clk_i = 1'b0;
  logic          i_reset = 1'b1;
  logic [31:0]   i_wb_adr = '0, i_wb_dat = '0;
  logic [3:0]    i_wb_sel = '0;
  logic          i_wb_we = 1'b0, i_wb_cyc = 1'b0, i_wb_stb = 1'b0;
  logic [31:0]   o_wb_dat;
  logic          o_wb_ack;
  logic          i_cpu_req = 1'b0, i_cpu_we = 1'b0;
  logic [AW-1:0] i_cpu_addr = '0;
  logic [7:0]    i_cpu_wdata = '0;
  logic          o_cpu_ack;
  logic [7:0]    o_cpu_rdata;
  logic          o_ram_en, o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [7:0]    o_ram_wdata;
  logic [7:0]    i_ram_rdata;

  ram_port_arbiter #(.ADDR_W(AW)) dut (
    .wb_clk_i(wb_clk_i), .i_reset(i_reset),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_n, act, want);
    end
  endtask

  // Byte RAM with one-cycle read latency; preset port loads contents during reset.
  logic [7:0]    ram [DEPTH];
  logic [7:0]    ram_rd_q = '0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_dat = '0;
  always @(posedge wb_clk_i) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (o_ram_en) begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
      else          ram_rd_q <= ram[o_ram_addr];
    end
  end
  assign i_ram_rdata = ram_rd_q;

  // Reference model: on a grant, the whole transaction is laid out as a per-cycle schedule.
  typedef struct {
    bit            en;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    bit            wb_ack;
    bit            wb_rd;
    logic [31:0]   wbdat;
    bit            cpu_ack;
    logic [7:0]    cpu_rdata;
  } exp_t;

  exp_t          sched [16];
  logic [7:0]    ref_mem [DEPTH];
  bit            model_on = 1'b0;
  int            free_at = 0;
  bit            last_cpu = 1'b0;
  logic [31:0]   last_rd = '0;
  exp_t          e;
  int            idx;
  bit            g_cpu;
  logic [AW-1:0] base;

  always @(negedge wb_clk_i) begin
    if (pre_we) ref_mem[pre_addr] = pre_dat;
    if (model_on) begin
      idx = cyc_n % 16;
      e = sched[idx];
      chk("ram_en", 32'(o_ram_en), 32'(e.en));
      if (e.en) begin
        chk("ram_we", 32'(o_ram_we), 32'(e.we));
        chk("ram_addr", 32'(o_ram_addr), 32'(e.addr));
        if (e.we) chk("ram_wdata", 32'(o_ram_wdata), 32'(e.wdata));
      end
      chk("wb_ack", 32'(o_wb_ack), 32'(e.wb_ack));
      if (e.wb_ack) begin
        if (e.wb_rd) last_rd = e.wbdat;
        chk("wb_dat", o_wb_dat, last_rd);
      end
      chk("cpu_ack", 32'(o_cpu_ack), 32'(e.cpu_ack));
      if (e.cpu_ack) chk("cpu_rdata", 32'(o_cpu_rdata), 32'(e.cpu_rdata));
      if (e.en && e.we) ref_mem[e.addr] = e.wdata;
      sched[idx] = '{default: 0};

      if (i_reset) begin
        for (int i = 0; i < 16; i++) sched[i] = '{default: 0};
        free_at  = cyc_n + 1;
        last_cpu = 1'b0;
        last_rd  = '0;
      end else if (cyc_n >= free_at && ((i_wb_cyc && i_wb_stb) || i_cpu_req)) begin
        if (i_wb_cyc && i_wb_stb && i_cpu_req) g_cpu = PRIO ? 1'b0 : !last_cpu;
        else                                   g_cpu = i_cpu_req;
        if (g_cpu) begin
          idx = (cyc_n + 1) % 16;
          sched[idx].en    = 1'b1;
          sched[idx].we    = i_cpu_we;
          sched[idx].addr  = i_cpu_addr;
          sched[idx].wdata = i_cpu_wdata;
          idx = (cyc_n + 2) % 16;
          sched[idx].cpu_ack   = 1'b1;
          sched[idx].cpu_rdata = i_cpu_we ? 8'h00 : ref_mem[i_cpu_addr];
          free_at  = cyc_n + 3;
          last_cpu = 1'b1;
        end else begin
          base = {i_wb_adr[AW-1:2], 2'b00};
          for (int k = 0; k < 4; k++) begin
            idx = (cyc_n + 1 + k) % 16;
            if (!i_wb_we || i_wb_sel[k]) begin
              sched[idx].en    = 1'b1;
              sched[idx].we    = i_wb_we;
              sched[idx].addr  = base + AW'(k);
              sched[idx].wdata = i_wb_dat[8*k +: 8];
            end
          end
          idx = (cyc_n + 6) % 16;
          sched[idx].wb_ack = 1'b1;
          sched[idx].wb_rd  = !i_wb_we;
          sched[idx].wbdat  = {ref_mem[base + AW'(3)], ref_mem[base + AW'(2)],
                               ref_mem[base + AW'(1)], ref_mem[base]};
          free_at  = cyc_n + 7;
          last_cpu = 1'b0;
        end
      end
    end
  end

  task automatic preset(input int a, input logic [7:0] d);
    pre_addr = AW'(a);
    pre_dat  = d;
    pre_we   = 1'b1;
    @(posedge wb_clk_i); #1;
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 i_reset = 1'b0;
  endtask

  // Host transaction; with scramble, address/data/select wander after the first cycle.
  task automatic host_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit scramble,
                          output int lat, output logic [31:0] rdat);
    int t0;
    bit got;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
    t0 = cyc_n; got = 1'b0; lat = -1; rdat = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge wb_clk_i);
      if (o_wb_ack) begin got = 1'b1; lat = cyc_n - t0; rdat = o_wb_dat; end
      @(posedge wb_clk_i); #1;
      if (!got && scramble) begin
        i_wb_adr = $urandom; i_wb_dat = $urandom; i_wb_sel = 4'($urandom);
      end
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    chk("wb_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic cpu_txn(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                         output int lat, output logic [7:0] rdat);
    int t0;
    bit got;
    i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = addr; i_cpu_wdata = wdata;
    t0 = cyc_n; got = 1'b0; lat = -1; rdat = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge wb_clk_i);
      if (o_cpu_ack) begin got = 1'b1; lat = cyc_n - t0; rdat = o_cpu_rdata; end
      @(posedge wb_clk_i); #1;
    end
    i_cpu_req = 1'b0;
    chk("cpu_ack_seen", 32'(got), 32'd1);
  endtask

  int          lat;
  logic [31:0] wrd;
  logic [7:0]  brd;
  byte         order [4];
  byte         exp_order [4];
  int          n_got, n_ack, n_en;

  initial begin
    @(posedge wb_clk_i); #1;
    model_on = 1'b1;
    for (int a = 0; a < DEPTH; a++) preset(a, 8'($urandom));
    preset(4, 8'h00); preset(5, 8'h11); preset(6, 8'h00); preset(7, 8'h22);
    preset(8, 8'hA0); preset(9, 8'hA1); preset(10, 8'hA2); preset(11, 8'hA3);

    @(negedge wb_clk_i);
    chk("rst_wb_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_cpu_ack", 32'(o_cpu_ack), 32'd0);
    chk("rst_wb_dat", o_wb_dat, 32'd0);
    chk("rst_cpu_rdata", 32'(o_cpu_rdata), 32'd0);
    chk("rst_ram_en", 32'(o_ram_en), 32'd0);
    chk("rst_ram_we", 32'(o_ram_we), 32'd0);
    chk("rst_ram_addr", 32'(o_ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(o_ram_wdata), 32'd0);
    @(posedge wb_clk_i); #1;
    i_reset = 1'b0;

    // Masked host write, then read-back merging untouched bytes.
    host_txn(1'b1, 32'h0000_0004, 32'hDDCC_BBAA, 4'b0101, 1'b0, lat, wrd);
    chk("hw_latency", 32'(lat), 32'd6);
    chk("hw_ram4", 32'(ram[4]), 32'hAA);
    chk("hw_ram5", 32'(ram[5]), 32'h11);
    chk("hw_ram6", 32'(ram[6]), 32'hCC);
    chk("hw_ram7", 32'(ram[7]), 32'h22);
    host_txn(1'b0, 32'h0000_0004, 32'h0, 4'b0000, 1'b0, lat, wrd);
    chk("hr_latency", 32'(lat), 32'd6);
    chk("hr_data", wrd, 32'h22CC_11AA);
    cpu_txn(1'b0, 8'h06, 8'h00, lat, brd);
    chk("cr_latency", 32'(lat), 32'd2);
    chk("cr_data", 32'(brd), 32'hCC);

    // Simultaneous continuous requests right after reset.
    do_reset();
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 8'h10;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h20; i_wb_sel = 4'hF;
    n_got = 0;
    for (int k = 0; k < 4; k++) order[k] = 0;
    for (int i = 0; i < 60 && n_got < 4; i++) begin
      @(negedge wb_clk_i);
      if (o_cpu_ack && n_got < 4) begin order[n_got] = "C"; n_got++; end
      if (o_wb_ack && n_got < 4)  begin order[n_got] = "H"; n_got++; end
    end
    @(posedge wb_clk_i); #1;
    i_cpu_req = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    if (PRIO) exp_order = '{"H", "H", "H", "H"};
    else      exp_order = '{"C", "H", "C", "H"};
    for (int k = 0; k < 4; k++) chk("tie_order", 32'(order[k]), 32'(exp_order[k]));
    repeat (10) @(posedge wb_clk_i);
    #1;

    // Reset lands while lane 1 is in flight: lane 2 must never be issued.
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 32'h8; i_wb_dat = 32'h4433_2211; i_wb_sel = 4'hF;
    @(posedge wb_clk_i); #1;
    @(posedge wb_clk_i); #1;
    i_reset = 1'b1;
    @(posedge wb_clk_i); #1;
    i_reset = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    n_ack = 0; n_en = 0;
    repeat (8) begin
      @(negedge wb_clk_i);
      if (o_wb_ack) n_ack++;
      if (o_ram_en) n_en++;
    end
    @(posedge wb_clk_i); #1;
    chk("rst_mid_no_ack", 32'(n_ack), 32'd0);
    chk("rst_mid_ram_idle", 32'(n_en), 32'd0);
    chk("rst_mid_ram8", 32'(ram[8]), 32'h11);
    chk("rst_mid_ram9", 32'(ram[9]), 32'h22);
    chk("rst_mid_ram10", 32'(ram[10]), 32'hA2);
    chk("rst_mid_ram11", 32'(ram[11]), 32'hA3);
    cpu_txn(1'b0, 8'h09, 8'h00, lat, brd);
    chk("rst_mid_idle_lat", 32'(lat), 32'd2);
    chk("rst_mid_cpu_rd", 32'(brd), 32'h22);

    // Random traffic from both ports, checked by the schedule model.
    fork
      begin : host_drv
        int          hl;
        logic [31:0] hd;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(3, 1)) @(posedge wb_clk_i);
          #1;
          host_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 1'b1, hl, hd);
        end
      end
      begin : cpu_drv
        int         cl;
        logic [7:0] cd;
        int         g;
        for (int t = 0; t < 60; t++) begin
          g = $urandom_range(3, 0);
          if (g > 0) begin
            repeat (g) @(posedge wb_clk_i);
            #1;
          end
          cpu_txn(1'($urandom), AW'($urandom), 8'($urandom), cl, cd);
        end
      end
    join
    repeat (10) @(posedge wb_clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc_n);
    $fatal(1);
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM byte-address width (RAM depth 2**ADDR_W bytes).
REQ-002 SHALL have wb_clk_i  in  1  clock; all logic on rising edge.
REQ-003 SHALL have i_reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have i_wb_adr  in  32  host byte address; bits [ADDR_W-1:2] select word, bits [1:0] and above ADDR_W ignored.
REQ-005 SHALL have i_wb_dat  in  32  host write data, lane k = bits [8k+7:8k].
REQ-006 SHALL have i_wb_sel  in  4  host byte-lane enables.
REQ-007 SHALL have i_wb_we  in  1  host write strobe.
REQ-008 SHALL have i_wb_cyc  in  1  host bus cycle.
REQ-009 SHALL have i_wb_stb  in  1  host strobe.
REQ-010 SHALL have o_wb_dat  out  32  host read data, valid in ack cycle.
REQ-011 SHALL have o_wb_ack  out  1  host acknowledge, one-cycle pulse.
REQ-012 SHALL have i_cpu_req  in  1  CPU byte-access request, held until ack.
REQ-013 SHALL have i_cpu_we  in  1  CPU write (1) / read (0).
REQ-014 SHALL have i_cpu_addr  in  ADDR_W  CPU byte address (fetch or data).
REQ-015 SHALL have i_cpu_wdata  in  8  CPU write byte.
REQ-016 SHALL have o_cpu_ack  out  1  CPU acknowledge, one-cycle pulse.
REQ-017 SHALL have o_cpu_rdata  out  8  CPU read byte, valid in ack cycle.
REQ-018 SHALL have o_ram_en  out  1  RAM access enable.
REQ-019 SHALL have o_ram_we  out  1  RAM write enable (qualified by o_ram_en).
REQ-020 SHALL have o_ram_addr  out  ADDR_W  RAM byte address.
REQ-021 SHALL have o_ram_wdata  out  8  RAM write byte.
REQ-022 SHALL have i_ram_rdata  in  8  RAM read byte, valid one cycle after o_ram_en with o_ram_we=0.

Function
REQ-023 SHALL be a single-owner FSM with states IDLE, HOST (lane counter 0..3), HOST_ACK, CPU, CPU_ACK; at most one RAM access per cycle.
REQ-024 SHALL in IDLE, when host request (i_wb_cyc & i_wb_stb) and/or i_cpu_req present, grant exactly one and enter HOST or CPU in the next cycle; no request -> stay IDLE, o_ram_en=0.
REQ-025 SHALL on tie grant the requester not granted most recently (last_grant bit); CPU wins the first tie after reset.
REQ-026 SHALL in HOST, cycles G..G+3, issue lane k at address {word,k[1:0]}; reads enable every lane; writes assert o_ram_en/o_ram_we only for lanes with i_wb_sel[k]=1 (unselected lanes idle, timing unchanged).
REQ-027 SHALL capture read lane k into o_wb_dat[8k+7:8k] from i_ram_rdata in cycle G+k+1; o_wb_ack=1 in cycle G+5 (HOST_ACK), o_wb_dat all-lane valid there; writes return previous o_wb_dat.
REQ-028 SHALL in CPU (cycle C) issue one access from i_cpu_addr/i_cpu_we/i_cpu_wdata; in C+1 (CPU_ACK) assert o_cpu_ack with o_cpu_rdata=i_ram_rdata (reads) or 0 (writes).
REQ-029 SHALL return to IDLE after HOST_ACK/CPU_ACK; requests still asserted in an ack cycle are not re-accepted until the IDLE cycle that follows.
REQ-030 SHALL never preempt a granted transaction; a CPU request arriving during HOST waits (worst-case CPU latency 8 cycles from request to ack).
REQ-031 SHALL ignore i_wb_adr/i_wb_sel/i_wb_dat changes after grant (sampled at grant).

Reset
REQ-032 SHALL on i_reset force IDLE, o_wb_ack=0, o_cpu_ack=0, o_wb_dat=0, o_cpu_rdata=0, o_ram_en=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, last_grant=host.
REQ-033 SHALL, reset mid-transaction, abandon it without ack; host lanes already written stay written.

Configuration
REQ-034 SHALL, with RAM_ARB_HOST_PRIO_EN defined, grant host on every tie (strict priority, last_grant unused); without it, alternate per REQ-025.

Structure
REQ-035 SHALL take state enum, lane count (4) and host ack latency (5) from shared package ram_arb_pkg.
REQ-036 SHALL be a single module; no sub-module is natural.

Verification
REQ-037 SHALL cover host write adr=0x04, dat=0xDDCCBBAA, sel=0b0101 -> RAM writes 0xAA@4, 0xCC@6 only; ack in G+5.
REQ-038 SHALL cover host read adr=0x04 after REQ-037 with RAM[5]=0x11, RAM[7]=0x22 -> o_wb_dat=0x22CC11AA.
REQ-039 SHALL cover CPU read addr=0x06 -> o_cpu_ack one cycle after grant, o_cpu_rdata=0xCC.
REQ-040 SHALL cover host and CPU requesting same cycle after reset, continuously -> grants CPU, host, CPU, host; with RAM_ARB_HOST_PRIO_EN, host first.
REQ-041 SHALL cover i_reset in HOST lane 2 of a write -> no ack, lanes 0-1 written, lanes 2-3 unchanged, FSM IDLE.
